rfa: RTL and testbench

- Register-file access arbiter between the eight execution-unit result queues: simd0..simd3 and simf0..simf3.
- Each cycle it grants at most one queue write access to the VGPR/SGPR write path.
- Arbitration is round-robin over pending queues.
- It sits between the FU result queues and the register-file write muxes. It drives the per-queue serviced acknowledge and a one-hot FU select for the write-data mux.

---
 rtl/rfa_pkg.sv | 19 +
 rtl/rr_arbiter_8.sv | 48 ++++
 rtl/rfa.sv | 70 +++++++
 tb/tb_rfa.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/rfa_pkg.sv
// Shared constants for the register-file access arbiter.
// Queue index constants double as bit positions in req/grant and in
// execvgprsgpr_select_fu[7:0].
package rfa_pkg;

  localparam int unsigned NUM_REQ   = 8;
  localparam int unsigned SEL_WIDTH = 16;
  localparam int unsigned PTR_WIDTH = $clog2(NUM_REQ);

  localparam int unsigned IDX_SIMD0 = 0;
  localparam int unsigned IDX_SIMD1 = 1;
  localparam int unsigned IDX_SIMD2 = 2;
  localparam int unsigned IDX_SIMD3 = 3;
  localparam int unsigned IDX_SIMF0 = 4;
  localparam int unsigned IDX_SIMF1 = 5;
  localparam int unsigned IDX_SIMF2 = 6;
  localparam int unsigned IDX_SIMF3 = 7;

endpackage

// File: rtl/rr_arbiter_8.sv
// Rotating-priority arbiter over eight requesters.
// Ports:
//   clk_i   - rising-edge clock
//   rst_ni  - asynchronous active-low reset (pointer returns to 0)
//   req_i   - request vector, one bit per requester
//   gnt_o   - one-hot grant, combinational from req_i and the pointer
// The pointer names the requester with highest priority; after a grant it
// moves to the index just past the winner, otherwise it holds.
module rr_arbiter_8
  import rfa_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  logic [PTR_WIDTH-1:0] ptr_q, ptr_d;
  logic [PTR_WIDTH-1:0] idx;
  logic [PTR_WIDTH-1:0] gnt_idx;
  logic                 found;

  // Scan ptr, ptr+1, ... modulo NUM_REQ; the 3-bit add wraps for free.
  always_comb begin
    gnt_o   = '0;
    found   = 1'b0;
    gnt_idx = ptr_q;
    idx     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = ptr_q + PTR_WIDTH'(k);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_idx    = idx;
        gnt_o[idx] = 1'b1;
      end
    end
    ptr_d = found ? gnt_idx + PTR_WIDTH'(1) : ptr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/rfa.sv
// Register-file access arbiter: picks at most one of the eight FU result
// queues (simd0..3, simf0..3) per cycle for the VGPR/SGPR write path.
// Ports:
//   clk, rst                   - clock, asynchronous active-low reset
//   simdN/simfN_queue_entry_valid     - queue has a pending write
//   simdN/simfN_queue_entry_serviced  - one-cycle grant/pop strobe
//   execvgprsgpr_select_fu     - one-hot FU select; upper 8 bits reserved (0)
// Requests are masked by rst so outputs are 0 in reset even with X valids.
module rfa
  import rfa_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 simd0_queue_entry_valid,
  input  logic                 simd1_queue_entry_valid,
  input  logic                 simd2_queue_entry_valid,
  input  logic                 simd3_queue_entry_valid,
  input  logic                 simf0_queue_entry_valid,
  input  logic                 simf1_queue_entry_valid,
  input  logic                 simf2_queue_entry_valid,
  input  logic                 simf3_queue_entry_valid,
  output logic                 simd0_queue_entry_serviced,
  output logic                 simd1_queue_entry_serviced,
  output logic                 simd2_queue_entry_serviced,
  output logic                 simd3_queue_entry_serviced,
  output logic                 simf0_queue_entry_serviced,
  output logic                 simf1_queue_entry_serviced,
  output logic                 simf2_queue_entry_serviced,
  output logic                 simf3_queue_entry_serviced,
  output logic [SEL_WIDTH-1:0] execvgprsgpr_select_fu
);

  logic [NUM_REQ-1:0] valid;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;

  always_comb begin
    valid            = '0;
    valid[IDX_SIMD0] = simd0_queue_entry_valid;
    valid[IDX_SIMD1] = simd1_queue_entry_valid;
    valid[IDX_SIMD2] = simd2_queue_entry_valid;
    valid[IDX_SIMD3] = simd3_queue_entry_valid;
    valid[IDX_SIMF0] = simf0_queue_entry_valid;
    valid[IDX_SIMF1] = simf1_queue_entry_valid;
    valid[IDX_SIMF2] = simf2_queue_entry_valid;
    valid[IDX_SIMF3] = simf3_queue_entry_valid;
  end

  // AND with rst resolves X valids to 0 while reset is asserted.
  assign req = valid & {NUM_REQ{rst}};

  rr_arbiter_8 u_arb (
    .clk_i  (clk),
    .rst_ni (rst),
    .req_i  (req),
    .gnt_o  (gnt)
  );

  assign simd0_queue_entry_serviced = gnt[IDX_SIMD0];
  assign simd1_queue_entry_serviced = gnt[IDX_SIMD1];
  assign simd2_queue_entry_serviced = gnt[IDX_SIMD2];
  assign simd3_queue_entry_serviced = gnt[IDX_SIMD3];
  assign simf0_queue_entry_serviced = gnt[IDX_SIMF0];
  assign simf1_queue_entry_serviced = gnt[IDX_SIMF1];
  assign simf2_queue_entry_serviced = gnt[IDX_SIMF2];
  assign simf3_queue_entry_serviced = gnt[IDX_SIMF3];

  assign execvgprsgpr_select_fu = SEL_WIDTH'(gnt);

endmodule

// File: tb/tb_rfa.sv
module tb_rfa;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  vld;
  wire  [7:0]  svc;
  wire  [15:0] sel;

  int checks   = 0;
  int failures = 0;
  int m_ptr    = 0;
  bit running  = 1'b0;

  always #5 clk = ~clk;

  rfa dut (
    .clk                        (clk),
    .rst                        (rst),
    .simd0_queue_entry_valid    (vld[0]),
    .simd1_queue_entry_valid    (vld[1]),
    .simd2_queue_entry_valid    (vld[2]),
    .simd3_queue_entry_valid    (vld[3]),
    .simf0_queue_entry_valid    (vld[4]),
    .simf1_queue_entry_valid    (vld[5]),
    .simf2_queue_entry_valid    (vld[6]),
    .simf3_queue_entry_valid    (vld[7]),
    .simd0_queue_entry_serviced (svc[0]),
    .simd1_queue_entry_serviced (svc[1]),
    .simd2_queue_entry_serviced (svc[2]),
    .simd3_queue_entry_serviced (svc[3]),
    .simf0_queue_entry_serviced (svc[4]),
    .simf1_queue_entry_serviced (svc[5]),
    .simf2_queue_entry_serviced (svc[6]),
    .simf3_queue_entry_serviced (svc[7]),
    .execvgprsgpr_select_fu     (sel)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference: rotate requests so the priority holder sits at bit 0, take the
  // lowest set bit, map back to the absolute index. -1 means no grant.
  function automatic int pick(input logic [7:0] r, input int p);
    logic [15:0] dbl;
    logic [7:0]  rot;
    dbl = {r, r};
    rot = dbl[p +: 8];
    for (int k = 0; k < 8; k++) begin
      if (rot[k]) return (p + k) % 8;
    end
    return -1;
  endfunction

  function automatic logic [15:0] expect_sel();
    int g;
    if (rst !== 1'b1) return 16'h0;
    g = pick(vld, m_ptr);
    if (g < 0) return 16'h0;
    return 16'h1 << g;
  endfunction

  // Model pointer: advances past the winner on each clock edge, cleared by reset.
  always @(posedge clk) begin
    int g;
    if (rst !== 1'b1) begin
      m_ptr = 0;
    end else begin
      g = pick(vld, m_ptr);
      if (g >= 0) m_ptr = (g + 1) % 8;
    end
  end

  always @(negedge rst) m_ptr = 0;

  // Per-cycle comparison against the model, sampled away from the active edge.
  always @(negedge clk) begin
    logic [15:0] e;
    if (running) begin
      e = expect_sel();
      chk("model_select_fu", {16'h0, sel}, {16'h0, e});
      chk("model_serviced", {24'h0, svc}, {24'h0, e[7:0]});
    end
  end

  task automatic set_vld(input logic [7:0] v);
    @(posedge clk);
    #1 vld = v;
  endtask

  initial begin
    vld = 8'bx;
    running = 1'b1;
    // X valids under reset must not reach the outputs.
    repeat (2) @(negedge clk);
    chk("reset_x_valid", {16'h0, sel}, 32'h0);
    set_vld(8'hFF);
    @(negedge clk);
    chk("reset_all_valid_sel", {16'h0, sel}, 32'h0);
    chk("reset_all_valid_svc", {24'h0, svc}, 32'h0);

    // Release: simd0 wins in the same cycle, then full rotation twice.
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("rotate_all", {16'h0, sel}, 32'h1 << (i % 8));
    end

    // Sparse requesters 1,3,5,7; pointer is at 0 after granting 7.
    set_vld(8'hAA);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rotate_sparse", {16'h0, sel}, 32'h1 << (2 * (i % 4) + 1));
    end

    // Idle: pointer frozen at 4 (just past index 3).
    set_vld(8'h00);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_zero", {16'h0, sel}, 32'h0);
    end
    set_vld(8'hFF);
    @(negedge clk);
    chk("resume_after_idle", {16'h0, sel}, 32'h0010);

    // Single requester simf2 granted every cycle.
    set_vld(8'h40);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("single_simf2_sel", {16'h0, sel}, 32'h0040);
      chk("single_simf2_svc", {31'h0, svc[6]}, 32'h1);
    end

    // Asynchronous reset between edges mid-rotation.
    set_vld(8'hFF);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("async_reset_drop", {16'h0, sel}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("restart_simd0", {16'h0, sel}, 32'h0001);

    // Randomized traffic with occasional mid-cycle reset pulses.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1 vld = 8'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
      end
    end

    @(negedge clk);
    running = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
